// File: rtl/rv32i_pkg.sv
// rv32i_pkg: encoder operation enum, RV32I opcode constants and canonical NOP
package rv32i_pkg;
  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
  } enc_op_t;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [31:0] RV_NOP = 32'h00000013;
endpackage

// File: rtl/instr_enc_core.sv
// instr_enc_core: combinational RV32I encoder with immediate legality checks
module instr_enc_core
  import rv32i_pkg::*;
(
  input  enc_op_t     op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);
  logic signed [31:0] s;
  logic is_r, is_ia, is_sh, is_ld, is_s, is_b, is_u, ok;
  logic i_ok, sh_ok, b_ok, j_ok, u_ok;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] enc;
  assign s     = imm;
  assign is_r  = op <= OP_AND;
  assign is_ia = op >= OP_ADDI && op <= OP_ANDI;
  assign is_sh = op >= OP_SLLI && op <= OP_SRAI;
  assign is_ld = op >= OP_LB && op <= OP_LHU;
  assign is_s  = op >= OP_SB && op <= OP_SW;
  assign is_b  = op >= OP_BEQ && op <= OP_BGEU;
  assign is_u  = op == OP_LUI || op == OP_AUIPC;
  assign i_ok  = s >= -2048 && s <= 2047;
  assign sh_ok = imm < 32'd32;
  assign b_ok  = !imm[0] && s >= -4096 && s <= 4094;
  assign j_ok  = !imm[0] && s >= -(1 <<< 20) && s <= (1 <<< 20) - 2;
  assign u_ok  = imm[11:0] == 12'd0;
  assign f7    = (op == OP_SUB || op == OP_SRA || op == OP_SRAI) ? 7'b0100000 : 7'b0000000;
  always_comb begin
    f3 = 3'd0;
    case (op)
      OP_SLL, OP_SLLI, OP_LH, OP_SH, OP_BNE:                f3 = 3'd1;
      OP_SLT, OP_SLTI, OP_LW, OP_SW:                       f3 = 3'd2;
      OP_SLTU, OP_SLTIU:                                   f3 = 3'd3;
      OP_XOR, OP_XORI, OP_LBU, OP_BLT:                     f3 = 3'd4;
      OP_SRL, OP_SRA, OP_SRLI, OP_SRAI, OP_LHU, OP_BGE:    f3 = 3'd5;
      OP_OR, OP_ORI, OP_BLTU:                              f3 = 3'd6;
      OP_AND, OP_ANDI, OP_BGEU:                            f3 = 3'd7;
      default:                                             f3 = 3'd0;
    endcase
  end
  assign enc = is_r  ? {f7, rs2, rs1, f3, rd, OPC_OP}
             : is_sh ? {f7, imm[4:0], rs1, f3, rd, OPC_OPIMM}
             : is_ia ? {imm[11:0], rs1, f3, rd, OPC_OPIMM}
             : is_ld ? {imm[11:0], rs1, f3, rd, OPC_LOAD}
             : op == OP_JALR ? {imm[11:0], rs1, 3'd0, rd, OPC_JALR}
             : is_s  ? {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE}
             : is_b  ? {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH}
             : op == OP_JAL ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL}
             : {imm[31:12], rd, op == OP_LUI ? OPC_LUI : OPC_AUIPC};
  // undefined enum values match no class and so fall out as illegal
  assign ok = is_r || ((is_ia || is_ld || is_s || op == OP_JALR) && i_ok) || (is_sh && sh_ok)
           || (is_b && b_ok) || (op == OP_JAL && j_ok) || (is_u && u_ok);
  assign instr = ok ? enc : RV_NOP;
  assign err   = !ok;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage valid/ready RV32I encoder with word address and error counters
module instr_encoder
  import rv32i_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  enc_op_t           in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  input  logic              addr_clr,
  output logic [15:0]       err_count
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  logic a_valid, enc_err, xfer, b_load;
  enc_op_t a_op;
  logic [4:0] a_rd, a_rs1, a_rs2;
  logic [31:0] a_imm, enc;
  instr_enc_core u_core (
    .op(a_op), .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .imm(a_imm), .instr(enc), .err(enc_err)
  );
  assign xfer     = out_valid && out_ready;
  assign b_load   = !out_valid || out_ready;
  assign in_ready = !a_valid || b_load;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid   <= 1'b0;
      a_op      <= OP_ADD;
      a_rd      <= '0;
      a_rs1     <= '0;
      a_rs2     <= '0;
      a_imm     <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      out_addr  <= BASE;
      err_count <= '0;
    end else begin
      if (in_ready) begin
        a_valid <= in_valid;
        if (in_valid) {a_op, a_rd, a_rs1, a_rs2, a_imm} <= {in_op, in_rd, in_rs1, in_rs2, in_imm};
      end
      if (b_load) out_valid <= a_valid;
      if (b_load && a_valid) {out_instr, out_err} <= {enc, enc_err};
      // a clear coinciding with a transfer wins over the increment
      if (addr_clr) out_addr <= BASE;
      else if (xfer) out_addr <= out_addr + 1'b1;
      if (xfer && out_err && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scoreboard bench for instr_encoder with ADDR_W=2
module tb_instr_encoder;
  import rv32i_pkg::*;
  typedef struct packed {logic [31:0] instr; logic err;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, addr_clr = 1'b0;
  logic in_ready, out_valid, out_err;
  enc_op_t in_op = OP_ADD;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0, out_instr;
  logic [1:0] out_addr;
  logic [15:0] err_count;
  int errors = 0, checks = 0;
  exp_t q[$];
  exp_t cur;
  logic [1:0] exp_addr = 2'd0;
  logic [15:0] exp_ec = 16'd0;
  bit acc;
  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .addr_clr(addr_clr), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    exp_t e;
    bit x;
    @(negedge clk);
    x = out_valid && out_ready;
    if (x) begin
      if (q.size() == 0) chk("unexpected_word", 32'(out_valid), 32'd0);
      else begin
        e = q.pop_front();
        chk("instr", out_instr, e.instr);
        chk("err", 32'(out_err), 32'(e.err));
        chk("addr", 32'(out_addr), 32'(exp_addr));
        if (e.err && exp_ec != 16'hFFFF) exp_ec++;
      end
    end
    exp_addr = addr_clr ? 2'd0 : x ? exp_addr + 2'd1 : exp_addr;
    if (in_valid && in_ready) begin
      q.push_back(cur);
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic present(input enc_op_t op, input logic [4:0] rd, rs1, rs2,
                         input logic [31:0] imm, ei, input logic ee);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    cur = '{instr: ei, err: ee};
    in_valid = 1'b1;
    acc = 1'b0;
  endtask
  task automatic wait_acc();
    for (int i = 0; i < 50 && !acc; i++) step();
    chk("accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask
  task automatic send(input enc_op_t op, input logic [4:0] rd, rs1, rs2,
                      input logic [31:0] imm, ei, input logic ee);
    present(op, rd, rs1, rs2, imm, ei, ee);
    wait_acc();
  endtask
  task automatic drain();
    for (int i = 0; i < 50 && q.size() > 0; i++) step();
    chk("drain_timeout", q.size(), 32'd0);
  endtask
  task automatic clr();
    addr_clr = 1'b1;
    step();
    addr_clr = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
    chk("lat_edge_n", 32'(out_valid), 32'd0);
    step();
    chk("lat_edge_n1", 32'(out_valid), 32'd1);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);
    send(OP_SRAI, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030D093, 1'b0);
    send(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 1'b0);
    send(OP_LUI, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
    send(OP_JAL, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFE, 32'hFFFFF0EF, 1'b0);
    send(OP_SW, 5'd0, 5'd2, 5'd3, 32'hFFFFFFFC, 32'hFE312E23, 1'b0);
    send(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0);
    send(OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd31, 32'h01F09093, 1'b0);
    drain();
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, RV_NOP, 1'b1);
    send(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd3, RV_NOP, 1'b1);
    send(OP_LUI, 5'd5, 5'd0, 5'd0, 32'h00000001, RV_NOP, 1'b1);
    drain();
    step();
    chk("err_count_3", 32'(err_count), 32'd3);
    send(OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd32, RV_NOP, 1'b1);
    send(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd1, RV_NOP, 1'b1);
    send(enc_op_t'(6'd50), 5'd1, 5'd1, 5'd1, 32'd0, RV_NOP, 1'b1);
    drain();
    step();
    chk("err_count_model", 32'(err_count), 32'(exp_ec));
    clr();
    out_ready = 1'b0;
    send(OP_ADD, 5'd4, 5'd1, 5'd2, 32'd0, 32'h00208233, 1'b0);
    send(OP_ADD, 5'd5, 5'd1, 5'd2, 32'd0, 32'h002082B3, 1'b0);
    present(OP_ADD, 5'd6, 5'd1, 5'd2, 32'd0, 32'h00208333, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_instr", out_instr, 32'h00208233);
      chk("bp_hold_addr", 32'(out_addr), 32'd0);
    end
    chk("bp_two_accepted", q.size(), 32'd2);
    out_ready = 1'b1;
    wait_acc();
    drain();
    clr();
    for (int i = 0; i < 5; i++) send(OP_ADDI, 5'(i), 5'd0, 5'd0, 32'(i), {12'(i), 5'd0, 3'd0, 5'(i), 7'b0010011}, 1'b0);
    drain();
    clr();
    out_ready = 1'b0;
    send(OP_ADD, 5'd7, 5'd1, 5'd2, 32'd0, 32'h002083B3, 1'b0);
    send(OP_ADD, 5'd8, 5'd1, 5'd2, 32'd0, 32'h00208433, 1'b0);
    out_ready = 1'b1;
    step();
    addr_clr = 1'b1;
    chk("clr_pre_addr", 32'(out_addr), 32'd1);
    step();
    addr_clr = 1'b0;
    chk("clr_post_addr", 32'(out_addr), 32'd0);
    send(OP_ADD, 5'd9, 5'd1, 5'd2, 32'd0, 32'h002084B3, 1'b0);
    drain();
    out_ready = 1'b0;
    send(OP_ADD, 5'd4, 5'd1, 5'd2, 32'd0, 32'h00208233, 1'b0);
    send(OP_ADD, 5'd5, 5'd1, 5'd2, 32'd0, 32'h002082B3, 1'b0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_out_addr", 32'(out_addr), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    exp_addr = 2'd0;
    exp_ec = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stale_word", 32'(out_valid), 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
